// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one single-ported memory between instruction fetch and
// load/store. One access at a time, fixed read latency LAT, data-first priority
// with a bounded data streak, and flush-driven discard of in-flight fetches.
// The memory strobe, address, write enable and write data are driven in the
// grant cycle and sampled by the memory on the closing edge of that cycle.
// Read data is captured LAT cycles later; the result pulse follows one cycle
// after capture.
module imem_arbiter #(
    parameter int WORD        = 32,
    parameter int ADDR        = 16,
    parameter int LAT         = 1,
    parameter int MAX_DSTREAK = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_req_i,
    input  logic [ADDR-1:0] if_addr_i,
    input  logic            if_flush_i,
    output logic [WORD-1:0] if_inst_o,
    output logic            if_valid_o,
    output logic            if_stall_o,
    input  logic            d_req_i,
    input  logic            d_we_i,
    input  logic [ADDR-1:0] d_addr_i,
    input  logic [WORD-1:0] d_wdata_i,
    output logic [WORD-1:0] d_rdata_o,
    output logic            d_done_o,
    output logic            mem_en_o,
    output logic            mem_we_o,
    output logic [ADDR-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic [WORD-1:0] mem_rdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] LAT_C = 3'(LAT);
    localparam logic [3:0] MAX_C = 4'(MAX_DSTREAK);

    localparam logic OWNER_FETCH = 1'b0;
    localparam logic OWNER_DATA  = 1'b1;

    logic [1:0]      state_q, state_d;
    logic            owner_q, owner_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [3:0]      streak_q, streak_d;
    logic            drop_q, drop_d;
    logic [WORD-1:0] if_inst_q, if_inst_d;
    logic            if_valid_q, if_valid_d;
    logic [WORD-1:0] d_rdata_q, d_rdata_d;
    logic            d_done_q, d_done_d;

    logic canGrant;
    logic dReqEff;
    logic fetchWins;
    logic grantF;
    logic grantD;
    logic capture;

    // Arbitration: data wins unless the data streak is exhausted; a data request
    // is invisible in its own done cycle so a slow-dropping req cannot re-grant.
    always_comb begin
        canGrant  = ((state_q == S_IDLE) || (state_q == S_DONE)) && !rst;
        dReqEff   = d_req_i && !d_done_q;
        fetchWins = if_req_i && (!dReqEff || (streak_q == MAX_C));
        grantF    = canGrant && fetchWins;
        grantD    = canGrant && dReqEff && !fetchWins;
        capture   = (state_q == S_BUSY) && (cnt_q == LAT_C);
    end

    // Memory port is driven straight from the winning requester in the grant cycle.
    always_comb begin
        mem_en_o    = grantF || grantD;
        mem_we_o    = grantD && d_we_i;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grantD) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (grantF) begin
            mem_addr_o  = if_addr_i;
        end
    end

    // Next-state logic for the FSM, latency counter, streak counter and drop flag.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        cnt_d      = cnt_q;
        streak_d   = streak_q;
        drop_d     = drop_q;
        if_inst_d  = if_inst_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_done_d   = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                drop_d = 1'b0;
                if (grantF || grantD) begin
                    state_d = S_BUSY;
                    cnt_d   = 3'd1;
                    owner_d = grantD ? OWNER_DATA : OWNER_FETCH;
                    drop_d  = grantF && if_flush_i;
                end else begin
                    state_d = S_IDLE;
                    cnt_d   = 3'd0;
                end
            end
            S_BUSY: begin
                if ((owner_q == OWNER_FETCH) && if_flush_i) begin
                    drop_d = 1'b1;
                end
                if (capture) begin
                    state_d = S_DONE;
                    cnt_d   = 3'd0;
                    if (owner_q == OWNER_FETCH) begin
                        if_inst_d  = mem_rdata_i;
                        if_valid_d = !drop_q && !if_flush_i;
                    end else begin
                        d_rdata_d = mem_rdata_i;
                        d_done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 3'd0;
                drop_d  = 1'b0;
            end
        endcase

        if (grantF) begin
            streak_d = 4'd0;
        end else if (grantD) begin
            if (!if_req_i) begin
                streak_d = 4'd0;
            end else if (streak_q != MAX_C) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    // State registers; reset abandons any access in flight without a result pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            owner_q    <= OWNER_FETCH;
            cnt_q      <= 3'd0;
            streak_q   <= 4'd0;
            drop_q     <= 1'b0;
            if_inst_q  <= '0;
            if_valid_q <= 1'b0;
            d_rdata_q  <= '0;
            d_done_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            streak_q   <= streak_d;
            drop_q     <= drop_d;
            if_inst_q  <= if_inst_d;
            if_valid_q <= if_valid_d;
            d_rdata_q  <= d_rdata_d;
            d_done_q   <= d_done_d;
        end
    end

    assign if_inst_o  = if_inst_q;
    assign if_valid_o = if_valid_q;
    assign if_stall_o = ~if_valid_q;
    assign d_rdata_o  = d_rdata_q;
    assign d_done_o   = d_done_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed scenarios against two arbiter instances, one with
// LAT=1 and one with LAT=3, each backed by its own latency-accurate memory model.
// Memory word i initially holds 32'hA000_0000 | i.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ifReq;
    logic [15:0] ifAddr;
    logic        ifFlush;
    logic        dReq;
    logic        dWe;
    logic [15:0] dAddr;
    logic [31:0] dWdata;

    logic [31:0] ifInst1, dRdata1, memWdata1, memRdata1;
    logic        ifValid1, ifStall1, dDone1, memEn1, memWe1;
    logic [15:0] memAddr1;

    logic [31:0] ifInst3, dRdata3, memWdata3, memRdata3;
    logic        ifValid3, ifStall3, dDone3, memEn3, memWe3;
    logic [15:0] memAddr3;

    logic [31:0] mem1 [256];
    logic [31:0] mem3 [256];
    logic [31:0] pipe1;
    logic [31:0] pipe3a, pipe3b, pipe3c;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    imem_arbiter #(.WORD(32), .ADDR(16), .LAT(1), .MAX_DSTREAK(4)) dut1 (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_flush_i(ifFlush),
        .if_inst_o(ifInst1), .if_valid_o(ifValid1), .if_stall_o(ifStall1),
        .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
        .d_rdata_o(dRdata1), .d_done_o(dDone1),
        .mem_en_o(memEn1), .mem_we_o(memWe1), .mem_addr_o(memAddr1),
        .mem_wdata_o(memWdata1), .mem_rdata_i(memRdata1)
    );

    imem_arbiter #(.WORD(32), .ADDR(16), .LAT(3), .MAX_DSTREAK(4)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_i(ifReq), .if_addr_i(ifAddr), .if_flush_i(ifFlush),
        .if_inst_o(ifInst3), .if_valid_o(ifValid3), .if_stall_o(ifStall3),
        .d_req_i(dReq), .d_we_i(dWe), .d_addr_i(dAddr), .d_wdata_i(dWdata),
        .d_rdata_o(dRdata3), .d_done_o(dDone3),
        .mem_en_o(memEn3), .mem_we_o(memWe3), .mem_addr_o(memAddr3),
        .mem_wdata_o(memWdata3), .mem_rdata_i(memRdata3)
    );

    // Memory contents start as a recognisable address-tagged pattern.
    initial begin
        for (int i = 0; i < 256; i++) begin
            mem1[i] = 32'hA000_0000 | 32'(i);
            mem3[i] = 32'hA000_0000 | 32'(i);
        end
    end

    // One-cycle latency memory for dut1.
    always @(posedge clk) begin
        if (memEn1 && memWe1) mem1[memAddr1[7:0]] <= memWdata1;
        pipe1 <= memEn1 ? mem1[memAddr1[7:0]] : 32'h0;
    end
    assign memRdata1 = pipe1;

    // Three-cycle latency memory for dut3.
    always @(posedge clk) begin
        if (memEn3 && memWe3) mem3[memAddr3[7:0]] <= memWdata3;
        pipe3a <= memEn3 ? mem3[memAddr3[7:0]] : 32'h0;
        pipe3b <= pipe3a;
        pipe3c <= pipe3b;
    end
    assign memRdata3 = pipe3c;

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ifReq   = 1'b0;
        ifAddr  = 16'h0;
        ifFlush = 1'b0;
        dReq    = 1'b0;
        dWe     = 1'b0;
        dAddr   = 16'h0;
        dWdata  = 32'h0;
    endtask

    task automatic doReset();
        clearInputs();
        rst = 1'b1;
        stepCycle();
        stepCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        #2;
        nChecks++; if (ifValid1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_valid got %b exp 0", ifValid1); end
        nChecks++; if (ifStall1 !== 1'b1) begin nFail++; $display("[TB] FAIL reset_stall got %b exp 1", ifStall1); end
        nChecks++; if (dDone1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_done got %b exp 0", dDone1); end
        nChecks++; if (memEn1 !== 1'b0) begin nFail++; $display("[TB] FAIL reset_en got %b exp 0", memEn1); end
        nChecks++; if (ifInst1 !== 32'h0) begin nFail++; $display("[TB] FAIL reset_inst got %h exp 0", ifInst1); end
        nChecks++; if (dRdata1 !== 32'h0) begin nFail++; $display("[TB] FAIL reset_rdata got %h exp 0", dRdata1); end
        nChecks++; if (ifStall3 !== 1'b1) begin nFail++; $display("[TB] FAIL reset_stall3 got %b exp 1", ifStall3); end
        stepCycle();
    endtask

    task automatic test_fetch_stream();
        logic expEn, expValid;
        doReset();
        for (int c = 0; c < 8; c++) begin
            ifReq  = (c < 6);
            ifAddr = 16'(c / 2);
            #2;
            expEn    = (c < 6) && (c % 2 == 0);
            expValid = (c >= 2) && (c <= 6) && (c % 2 == 0);
            nChecks++; if (memEn1 !== expEn) begin nFail++; $display("[TB] FAIL fetch_en c=%0d got %b exp %b", c, memEn1, expEn); end
            if (expEn) begin
                nChecks++; if (memAddr1 !== 16'(c / 2)) begin nFail++; $display("[TB] FAIL fetch_addr c=%0d got %h exp %h", c, memAddr1, 16'(c / 2)); end
            end
            nChecks++; if (ifValid1 !== expValid) begin nFail++; $display("[TB] FAIL fetch_valid c=%0d got %b exp %b", c, ifValid1, expValid); end
            nChecks++; if (ifStall1 !== !expValid) begin nFail++; $display("[TB] FAIL fetch_stall c=%0d got %b exp %b", c, ifStall1, !expValid); end
            if (expValid) begin
                nChecks++; if (ifInst1 !== (32'hA000_0000 | 32'(c / 2 - 1))) begin nFail++; $display("[TB] FAIL fetch_inst c=%0d got %h exp %h", c, ifInst1, 32'hA000_0000 | 32'(c / 2 - 1)); end
            end
            stepCycle();
        end
    endtask

    task automatic test_data_priority();
        doReset();
        ifReq = 1'b1; ifAddr = 16'h0005; dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0040;
        #2;
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL prio_en0 got %b exp 1", memEn1); end
        nChecks++; if (memAddr1 !== 16'h0040) begin nFail++; $display("[TB] FAIL prio_addr0 got %h exp 0040", memAddr1); end
        nChecks++; if (memWe1 !== 1'b0) begin nFail++; $display("[TB] FAIL prio_we0 got %b exp 0", memWe1); end
        stepCycle();
        #2;
        nChecks++; if (memEn1 !== 1'b0) begin nFail++; $display("[TB] FAIL prio_en1 got %b exp 0", memEn1); end
        stepCycle();
        #2;
        nChecks++; if (dDone1 !== 1'b1) begin nFail++; $display("[TB] FAIL prio_done2 got %b exp 1", dDone1); end
        nChecks++; if (dRdata1 !== 32'hA000_0040) begin nFail++; $display("[TB] FAIL prio_rdata2 got %h exp a0000040", dRdata1); end
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL prio_en2 got %b exp 1", memEn1); end
        nChecks++; if (memAddr1 !== 16'h0005) begin nFail++; $display("[TB] FAIL prio_addr2 got %h exp 0005", memAddr1); end
        stepCycle();
        dReq = 1'b0; ifReq = 1'b0;
        #2;
        nChecks++; if (memEn1 !== 1'b0) begin nFail++; $display("[TB] FAIL prio_en3 got %b exp 0", memEn1); end
        nChecks++; if (dDone1 !== 1'b0) begin nFail++; $display("[TB] FAIL prio_done3 got %b exp 0", dDone1); end
        stepCycle();
        #2;
        nChecks++; if (ifValid1 !== 1'b1) begin nFail++; $display("[TB] FAIL prio_valid4 got %b exp 1", ifValid1); end
        nChecks++; if (ifInst1 !== 32'hA000_0005) begin nFail++; $display("[TB] FAIL prio_inst4 got %h exp a0000005", ifInst1); end
        stepCycle();
    endtask

    task automatic test_streak();
        logic        expEn;
        logic [15:0] expAddr;
        doReset();
        dReq = 1'b1; dWe = 1'b0; dAddr = 16'h0020; ifAddr = 16'h0008;
        for (int c = 0; c < 15; c++) begin
            ifReq = !(c inside {2, 5, 8, 11});
            #2;
            expEn   = (c inside {0, 3, 6, 9, 12, 14});
            expAddr = (c == 12) ? 16'h0008 : 16'h0020;
            nChecks++; if (memEn1 !== expEn) begin nFail++; $display("[TB] FAIL streak_en c=%0d got %b exp %b", c, memEn1, expEn); end
            if (expEn) begin
                nChecks++; if (memAddr1 !== expAddr) begin nFail++; $display("[TB] FAIL streak_addr c=%0d got %h exp %h", c, memAddr1, expAddr); end
            end
            if (c == 14) begin
                nChecks++; if (ifValid1 !== 1'b1) begin nFail++; $display("[TB] FAIL streak_valid got %b exp 1", ifValid1); end
                nChecks++; if (ifInst1 !== 32'hA000_0008) begin nFail++; $display("[TB] FAIL streak_inst got %h exp a0000008", ifInst1); end
            end
            stepCycle();
        end
    endtask

    task automatic test_flush();
        doReset();
        ifReq = 1'b1; ifAddr = 16'h0003;
        #2;
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL flush_en0 got %b exp 1", memEn1); end
        stepCycle();
        ifReq = 1'b0; ifFlush = 1'b1;
        #2;
        nChecks++; if (memEn1 !== 1'b0) begin nFail++; $display("[TB] FAIL flush_en1 got %b exp 0", memEn1); end
        stepCycle();
        ifFlush = 1'b0; ifReq = 1'b1; ifAddr = 16'h0009;
        #2;
        nChecks++; if (ifValid1 !== 1'b0) begin nFail++; $display("[TB] FAIL flush_valid2 got %b exp 0", ifValid1); end
        nChecks++; if (ifStall1 !== 1'b1) begin nFail++; $display("[TB] FAIL flush_stall2 got %b exp 1", ifStall1); end
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL flush_en2 got %b exp 1", memEn1); end
        nChecks++; if (memAddr1 !== 16'h0009) begin nFail++; $display("[TB] FAIL flush_addr2 got %h exp 0009", memAddr1); end
        stepCycle();
        ifReq = 1'b0;
        stepCycle();
        #2;
        nChecks++; if (ifValid1 !== 1'b1) begin nFail++; $display("[TB] FAIL flush_valid4 got %b exp 1", ifValid1); end
        nChecks++; if (ifInst1 !== 32'hA000_0009) begin nFail++; $display("[TB] FAIL flush_inst4 got %h exp a0000009", ifInst1); end
        stepCycle();
        ifReq = 1'b1; ifAddr = 16'h0007; ifFlush = 1'b1;
        #2;
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL flush_en5 got %b exp 1", memEn1); end
        stepCycle();
        ifReq = 1'b0; ifFlush = 1'b0;
        stepCycle();
        #2;
        nChecks++; if (ifValid1 !== 1'b0) begin nFail++; $display("[TB] FAIL flush_valid7 got %b exp 0", ifValid1); end
        stepCycle();
    endtask

    task automatic test_store_load();
        doReset();
        dReq = 1'b1; dWe = 1'b1; dAddr = 16'h0010; dWdata = 32'hDEAD_BEEF;
        #2;
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL st_en0 got %b exp 1", memEn1); end
        nChecks++; if (memWe1 !== 1'b1) begin nFail++; $display("[TB] FAIL st_we0 got %b exp 1", memWe1); end
        nChecks++; if (memWdata1 !== 32'hDEAD_BEEF) begin nFail++; $display("[TB] FAIL st_wdata0 got %h exp deadbeef", memWdata1); end
        stepCycle();
        stepCycle();
        dWe = 1'b0;
        #2;
        nChecks++; if (dDone1 !== 1'b1) begin nFail++; $display("[TB] FAIL st_done2 got %b exp 1", dDone1); end
        nChecks++; if (memEn1 !== 1'b0) begin nFail++; $display("[TB] FAIL st_ignore2 got %b exp 0", memEn1); end
        stepCycle();
        #2;
        nChecks++; if (memEn1 !== 1'b1) begin nFail++; $display("[TB] FAIL ld_en3 got %b exp 1", memEn1); end
        nChecks++; if (memWe1 !== 1'b0) begin nFail++; $display("[TB] FAIL ld_we3 got %b exp 0", memWe1); end
        stepCycle();
        stepCycle();
        dReq = 1'b0;
        #2;
        nChecks++; if (dDone1 !== 1'b1) begin nFail++; $display("[TB] FAIL ld_done5 got %b exp 1", dDone1); end
        nChecks++; if (dRdata1 !== 32'hDEAD_BEEF) begin nFail++; $display("[TB] FAIL ld_rdata5 got %h exp deadbeef", dRdata1); end
        stepCycle();
        #2;
        nChecks++; if (dDone1 !== 1'b0) begin nFail++; $display("[TB] FAIL ld_done6 got %b exp 0", dDone1); end
        stepCycle();
    endtask

    task automatic test_reset_midflight();
        doReset();
        ifReq = 1'b1; ifAddr = 16'h0004;
        #2;
        nChecks++; if (memEn3 !== 1'b1) begin nFail++; $display("[TB] FAIL rmid_en0 got %b exp 1", memEn3); end
        stepCycle();
        ifReq = 1'b0;
        stepCycle();
        rst = 1'b1;
        stepCycle();
        rst = 1'b0;
        #2;
        nChecks++; if (ifValid3 !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_valid3 got %b exp 0", ifValid3); end
        nChecks++; if (ifStall3 !== 1'b1) begin nFail++; $display("[TB] FAIL rmid_stall3 got %b exp 1", ifStall3); end
        nChecks++; if (memEn3 !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_en3 got %b exp 0", memEn3); end
        nChecks++; if (ifInst3 !== 32'h0) begin nFail++; $display("[TB] FAIL rmid_inst3 got %h exp 0", ifInst3); end
        nChecks++; if (dDone3 !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_done3 got %b exp 0", dDone3); end
        stepCycle();
        for (int c = 4; c < 7; c++) begin
            #2;
            nChecks++; if (ifValid3 !== 1'b0) begin nFail++; $display("[TB] FAIL rmid_valid c=%0d got %b exp 0", c, ifValid3); end
            stepCycle();
        end
        ifReq = 1'b1; ifAddr = 16'h0006;
        #2;
        nChecks++; if (memEn3 !== 1'b1) begin nFail++; $display("[TB] FAIL lat3_en7 got %b exp 1", memEn3); end
        stepCycle();
        ifReq = 1'b0;
        for (int c = 8; c < 12; c++) begin
            #2;
            nChecks++; if (ifValid3 !== (c == 11)) begin nFail++; $display("[TB] FAIL lat3_valid c=%0d got %b exp %b", c, ifValid3, (c == 11)); end
            if (c == 11) begin
                nChecks++; if (ifInst3 !== 32'hA000_0006) begin nFail++; $display("[TB] FAIL lat3_inst got %h exp a0000006", ifInst3); end
            end
            stepCycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        clearInputs();
        #1;
        test_reset();
        test_fetch_stream();
        test_data_priority();
        test_streak();
        test_flush();
        test_store_load();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
